// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/external two-master arbiter for the single-port data memory.
// Define DMARB_STARVE_EN to enable the starvation counter and forced external slots.
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_mem_w,
  input  logic        cpu_mem_r,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        dm_wr,
  output logic        dm_re,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  typedef enum logic {CPU_OWN, EXT_OWN} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       cpu_act;
  logic       gnt;
  logic       starve_hit;

  assign cpu_act = cpu_mem_w | cpu_mem_r;

`ifdef DMARB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] wait_cnt;

  // wait_cnt is always 0 right after a burst, so the CPU keeps the following cycle.
  assign starve_hit = (wait_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= 4'd0;
    end else if (ext_req && !gnt) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= CPU_OWN;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    gnt       = 1'b0;
    state_nxt = state;
    beat_nxt  = beat_cnt;
    if (rstn) begin
      case (state)
        CPU_OWN: begin
          gnt = ext_req & (!cpu_act | starve_hit);
          if (gnt && ext_lock && (MAX_BURST > 1)) begin
            state_nxt = EXT_OWN;
            beat_nxt  = 4'd1;
          end
        end
        EXT_OWN: begin
          gnt = ext_req;
          if (!ext_req) begin
            state_nxt = CPU_OWN;
            beat_nxt  = 4'd0;
          end else if (!ext_lock || (beat_cnt + 4'd1 == BURST_MAX)) begin
            state_nxt = CPU_OWN;
            beat_nxt  = 4'd0;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
        default: state_nxt = CPU_OWN;
      endcase
    end
  end

  assign ext_gnt   = gnt;
  assign cpu_stall = cpu_act & gnt;
  assign cpu_rdata = dm_dout;

  // During reset the memory port is fully quiet, including address and data.
  assign dm_wr   = rstn & (gnt ? ext_we : cpu_mem_w);
  assign dm_re   = rstn & (gnt ? !ext_we : cpu_mem_r);
  assign dm_addr = !rstn ? 32'd0 : (gnt ? ext_addr : cpu_addr);
  assign dm_din  = !rstn ? 32'd0 : (gnt ? ext_wdata : cpu_wdata);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= 32'd0;
    end else if (gnt && !ext_we) begin
      ext_rvalid <= 1'b1;
      ext_rdata  <= dm_dout;
    end else begin
      ext_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed and randomized check of dm_arbiter against a behavioural model.
module tb_dm_arbiter;

  localparam int SL = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_mem_w, cpu_mem_r;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        dm_wr, dm_re;
  logic [31:0] dm_addr, dm_din, dm_dout;

  dm_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_mem_w(cpu_mem_w), .cpu_mem_r(cpu_mem_r), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dm_wr(dm_wr), .dm_re(dm_re), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Data memory attached to the arbiter's dm port.
  logic [31:0] mem [64];
  logic        mem_clr;
  assign dm_dout = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (dm_wr) begin
      mem[dm_addr[7:2]] <= dm_din;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: intended memory contents plus arbitration bookkeeping.
  logic [31:0] refmem [64];
  bit          m_burst;
  int          m_beats, m_wait;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          last_stall, last_pend;

  logic        s_gnt, s_stall, s_wr, s_rvalid;
  logic [31:0] s_erdata, s_crdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit cw, input bit cr, input logic [31:0] ca, input logic [31:0] cd,
                     input bit er, input bit ewe, input bit elk, input logic [31:0] ea,
                     input logic [31:0] ed);
    cpu_mem_w = cw; cpu_mem_r = cr; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ewe; ext_lock = elk; ext_addr = ea; ext_wdata = ed;
  endtask

  // Called just after inputs change at a falling edge; returns at the next falling edge.
  task automatic step();
    bit          act, starve, e_gnt, e_stall, e_wr, e_re;
    logic [31:0] e_addr, e_din;
    int          ci, ei;
    #2;
    act = cpu_mem_w || cpu_mem_r;
`ifdef DMARB_STARVE_EN
    starve = (m_wait == SL);
`else
    starve = 1'b0;
`endif
    if (!rstn)        e_gnt = 1'b0;
    else if (m_burst) e_gnt = ext_req;
    else              e_gnt = ext_req && (!act || starve);
    e_stall = act && e_gnt;
    if (!rstn) begin
      e_wr = 0; e_re = 0; e_addr = 0; e_din = 0;
    end else if (e_gnt) begin
      e_wr = ext_we; e_re = !ext_we; e_addr = ext_addr; e_din = ext_wdata;
    end else begin
      e_wr = cpu_mem_w; e_re = cpu_mem_r; e_addr = cpu_addr; e_din = cpu_wdata;
    end
    ci = int'(cpu_addr[7:2]);
    ei = int'(ext_addr[7:2]);

    chk("ext_gnt", 32'(ext_gnt), 32'(e_gnt));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("dm_wr", 32'(dm_wr), 32'(e_wr));
    chk("dm_re", 32'(dm_re), 32'(e_re));
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_din", dm_din, e_din);
    chk("ext_rvalid", 32'(ext_rvalid), rstn ? 32'(m_rvalid) : 32'd0);
    chk("ext_rdata", ext_rdata, rstn ? m_rdata : 32'd0);
    if (rstn && cpu_mem_r && !e_stall) chk("cpu_rdata", cpu_rdata, refmem[ci]);

    s_gnt = ext_gnt; s_stall = cpu_stall; s_wr = dm_wr;
    s_rvalid = ext_rvalid; s_erdata = ext_rdata; s_crdata = cpu_rdata;

    if (!rstn) begin
      m_burst = 0; m_beats = 0; m_wait = 0; m_rvalid = 0; m_rdata = 32'd0;
    end else begin
      m_rvalid = e_gnt && !ext_we;
      if (m_rvalid) m_rdata = refmem[ei];
      if (e_gnt && ext_we)          refmem[ei] = ext_wdata;
      else if (!e_gnt && cpu_mem_w) refmem[ci] = cpu_wdata;
      m_wait = (ext_req && !e_gnt) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
      if (m_burst) begin
        if (!ext_req || !ext_lock || (m_beats + 1 == MB)) begin
          m_burst = 0; m_beats = 0;
        end else begin
          m_beats++;
        end
      end else if (e_gnt && ext_lock && MB > 1) begin
        m_burst = 1; m_beats = 1;
      end
    end
    last_stall = e_stall;
    last_pend  = rstn && ext_req && !e_gnt;
    @(negedge clk);
  endtask

  logic [5:0] gpat, spat, exp_starve;
  bit         got;
  int         r;

  initial begin
    rstn = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) refmem[i] = 32'd0;
    m_burst = 0; m_beats = 0; m_wait = 0; m_rvalid = 0; m_rdata = 32'd0;
    drv(1, 0, 32'h10, 32'h1234, 1, 1, 1, 32'h14, 32'h5678);
    @(negedge clk);
    step();
    chk("rst_dm_wr", 32'(s_wr), 32'd0);
    chk("rst_ext_gnt", 32'(s_gnt), 32'd0);
    chk("rst_cpu_stall", 32'(s_stall), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata", s_erdata, 32'd0);
    step();
    mem_clr = 1'b0; rstn = 1'b1;

    // CPU store then load
    drv(1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0); step();
    chk("cpu_st_stall", 32'(s_stall), 32'd0);
    chk("cpu_st_wr", 32'(s_wr), 32'd1);
    drv(0, 1, 32'h10, 0, 0, 0, 0, 0, 0); step();
    chk("cpu_ld_data", s_crdata, 32'hDEADBEEF);
    chk("cpu_ld_gnt", 32'(s_gnt), 32'd0);

    // External read with CPU idle
    drv(0, 0, 0, 0, 1, 0, 0, 32'h10, 0); step();
    chk("ext_rd_gnt", 32'(s_gnt), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("ext_rd_valid", 32'(s_rvalid), 32'd1);
    chk("ext_rd_data", s_erdata, 32'hDEADBEEF);
    step();
    chk("ext_rd_valid_drop", 32'(s_rvalid), 32'd0);

    // Starvation with CPU busy every cycle
    gpat = 0; got = 0;
    for (int i = 0; i < 6; i++) begin
      drv(0, 1, 32'h10, 0, !got, 0, 0, 32'h10, 0); step();
      gpat[i] = s_gnt;
      got = got | s_gnt;
    end
`ifdef DMARB_STARVE_EN
    exp_starve = 6'b010000;
`else
    exp_starve = 6'b000000;
`endif
    chk("starve_pattern", 32'(gpat), 32'(exp_starve));

    // Locked burst of MB writes, then guaranteed CPU cycle
    gpat = 0; spat = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drv(0, 0, 0, 0, 1, 1, 1, 32'h20, 32'hA0);
      else if (i < 4)  drv(0, 1, 32'h0, 0, 1, 1, 1, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i));
      else if (i == 4) drv(0, 1, 32'h0, 0, 1, 1, 0, 32'h34, 32'hA4);
      else             drv(0, 0, 0, 0, 1, 1, 0, 32'h34, 32'hA4);
      step();
      gpat[i] = s_gnt; spat[i] = s_stall;
    end
    chk("burst_gnt", 32'(gpat), 32'h2F);
    chk("burst_stall", 32'(spat), 32'h0E);
    drv(0, 1, 32'h2C, 0, 0, 0, 0, 0, 0); step();
    chk("burst_last_data", s_crdata, 32'hA3);

    // Ext write and CPU load to the same address in one cycle
    drv(0, 0, 0, 0, 1, 1, 1, 32'h3C, 32'h77); step();
    drv(0, 1, 32'h30, 0, 1, 1, 0, 32'h30, 32'h55); step();
    chk("coll_gnt", 32'(s_gnt), 32'd1);
    chk("coll_stall", 32'(s_stall), 32'd1);
    drv(0, 1, 32'h30, 0, 0, 0, 0, 0, 0); step();
    chk("coll_retry_data", s_crdata, 32'h55);
    chk("coll_retry_stall", 32'(s_stall), 32'd0);

    // Reset during beat 2 of a burst
    drv(0, 0, 0, 0, 1, 1, 1, 32'h40, 32'h99); step();
    drv(0, 1, 32'h0, 0, 1, 1, 1, 32'h44, 32'h98); rstn = 1'b0; step();
    chk("midrst_gnt", 32'(s_gnt), 32'd0);
    chk("midrst_wr", 32'(s_wr), 32'd0);
    chk("midrst_stall", 32'(s_stall), 32'd0);
    rstn = 1'b1;
    drv(0, 1, 32'h44, 0, 0, 0, 0, 0, 0); step();
    chk("postrst_stall", 32'(s_stall), 32'd0);
    chk("postrst_data", s_crdata, 32'd0);

    // Randomized traffic with protocol-correct request holding
    last_stall = 0; last_pend = 0;
    for (int k = 0; k < 3000; k++) begin
      rstn = ($urandom_range(0, 299) != 0);
      if (!last_stall) begin
        r = int'($urandom_range(0, 9));
        cpu_mem_w = (r < 3);
        cpu_mem_r = (r >= 3 && r < 7);
        cpu_addr  = 32'($urandom_range(0, 15)) << 2;
        cpu_wdata = $urandom;
      end
      if (!last_pend) begin
        ext_req   = ($urandom_range(0, 2) != 0);
        ext_we    = $urandom_range(0, 1) == 1;
        ext_lock  = ($urandom_range(0, 2) != 0);
        ext_addr  = 32'($urandom_range(0, 15)) << 2;
        ext_wdata = $urandom;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
